// File: rtl/wb_lcd_sequencer.sv
// Wishbone pipelined master that initialises an HD44780 LCD slave and refreshes it from a 32-byte shadow buffer.
// Optional ack timeout with sticky o_err: define WB_LCD_SEQUENCER_TIMEOUT_EN.
module wb_lcd_sequencer #(
    parameter logic [29:0] LCD_BASE_ADDR    = 30'h0,
    parameter int unsigned POWERUP_CYCLES   = 750000,
    parameter int unsigned CMD_GAP_CYCLES   = 2000,
    parameter int unsigned CLEAR_GAP_CYCLES = 80000,
    parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [29:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall,
    input  logic [31:0] i_wb_data,
    input  logic        i_char_we,
    input  logic [4:0]  i_char_addr,
    input  logic [7:0]  i_char_data,
    input  logic        i_refresh,
    output logic        o_init_done,
    output logic        o_busy,
    output logic        o_err
);
    localparam int unsigned MAX_A      = (POWERUP_CYCLES > CMD_GAP_CYCLES) ? POWERUP_CYCLES : CMD_GAP_CYCLES;
    localparam int unsigned MAX_CYCLES = (MAX_A > CLEAR_GAP_CYCLES) ? MAX_A : CLEAR_GAP_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_GAP_CYCLES - 1);
    localparam logic [5:0] INIT_LAST_IDX = 6'd3;
    localparam logic [5:0] REF_LAST_IDX  = 6'd33;
    localparam logic [5:0] LINE2_IDX     = 6'd17;

    typedef enum logic [2:0] {S_PWRUP, S_IDLE, S_REQ, S_WAIT, S_GAP} state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d, gap_last;
    logic [5:0]       idx, idx_d, idx_last;
    logic             in_init, in_init_d, dirty, dirty_d;
    logic             cyc_d, stb_d, we_d, init_done_d, busy_d;
    logic [29:0]      addr_d;
    logic [31:0]      data_d;
    logic [3:0]       sel_d;
    logic             issue, xfer_end, rs;
    logic [7:0]       tx_byte;
    logic [7:0]       shadow [32];

    logic unused_ok;
`ifdef WB_LCD_SEQUENCER_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt, to_cnt_d;
    logic            err_d;
    assign unused_ok = &{1'b0, i_wb_data};
`else
    assign unused_ok = &{1'b0, i_wb_data, 32'(TIMEOUT_CYCLES)};
    assign o_err     = 1'b0;
`endif

    // Shadow character buffer, spaces after reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 32; i++) shadow[i] <= 8'h20;
        end else if (i_char_we) begin
            shadow[i_char_addr] <= i_char_data;
        end
    end

    // Next-state, bus sub-sequence and registered output values
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        idx_d       = idx;
        in_init_d   = in_init;
        dirty_d     = dirty;
        cyc_d       = o_wb_cyc;
        stb_d       = o_wb_stb;
        we_d        = o_wb_we;
        sel_d       = o_wb_sel;
        addr_d      = o_wb_addr;
        data_d      = o_wb_data;
        init_done_d = o_init_done;
        issue       = 1'b0;
        xfer_end    = 1'b0;
        rs          = 1'b0;
        tx_byte     = 8'h00;
        gap_last    = (!o_wb_addr[0] && o_wb_data[7:0] == 8'h01) ? CLEAR_LAST : CMD_LAST;
        idx_last    = in_init ? INIT_LAST_IDX : REF_LAST_IDX;
`ifdef WB_LCD_SEQUENCER_TIMEOUT_EN
        to_cnt_d    = to_cnt;
        err_d       = o_err;
`endif
        case (state)
            S_PWRUP: begin
                if (cnt == PWR_LAST) begin
                    cnt_d     = '0;
                    in_init_d = 1'b1;
                    idx_d     = '0;
                    issue     = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_IDLE: begin
                if (dirty || i_refresh) begin
                    dirty_d   = 1'b0;
                    in_init_d = 1'b0;
                    idx_d     = '0;
                    issue     = 1'b1;
                end
            end
            S_REQ: begin
                if (!i_wb_stall) begin
                    stb_d = 1'b0;
                    if (i_wb_ack) xfer_end = 1'b1;
                    else          state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_wb_ack) xfer_end = 1'b1;
            end
            S_GAP: begin
                if (cnt == gap_last) begin
                    cnt_d = '0;
                    if (idx == idx_last) begin
                        state_d = S_IDLE;
                        if (in_init) init_done_d = 1'b1;
                    end else begin
                        idx_d = idx + 6'd1;
                        issue = 1'b1;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: state_d = S_PWRUP;
        endcase
`ifdef WB_LCD_SEQUENCER_TIMEOUT_EN
        if (state == S_REQ || state == S_WAIT) begin
            to_cnt_d = to_cnt + TO_W'(1);
            if (!xfer_end && to_cnt == TO_LAST) begin
                xfer_end = 1'b1;
                err_d    = 1'b1;
            end
        end
`endif
        if (xfer_end) begin
            state_d = S_GAP;
            cnt_d   = '0;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
            sel_d   = 4'b0000;
        end
        // Payload is sampled from the shadow buffer at the moment the request is issued
        if (issue) begin
            if (in_init_d) begin
                case (idx_d[1:0])
                    2'd0:    tx_byte = 8'h38;
                    2'd1:    tx_byte = 8'h0C;
                    2'd2:    tx_byte = 8'h01;
                    default: tx_byte = 8'h06;
                endcase
            end else if (idx_d == 6'd0) begin
                tx_byte = 8'h80;
            end else if (idx_d == LINE2_IDX) begin
                tx_byte = 8'hC0;
            end else if (idx_d < LINE2_IDX) begin
                rs      = 1'b1;
                tx_byte = shadow[5'(idx_d - 6'd1)];
            end else begin
                rs      = 1'b1;
                tx_byte = shadow[5'(idx_d - 6'd2)];
            end
            state_d = S_REQ;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            we_d    = 1'b1;
            sel_d   = 4'b0001;
            addr_d  = LCD_BASE_ADDR | 30'(rs);
            data_d  = {24'h0, tx_byte};
`ifdef WB_LCD_SEQUENCER_TIMEOUT_EN
            to_cnt_d = '0;
`endif
        end
        if (i_char_we) dirty_d = 1'b1;
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= S_PWRUP;
            cnt         <= '0;
            idx         <= '0;
            in_init     <= 1'b1;
            dirty       <= 1'b1;
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_wb_we     <= 1'b0;
            o_wb_sel    <= 4'b0000;
            o_wb_addr   <= '0;
            o_wb_data   <= '0;
            o_init_done <= 1'b0;
            o_busy      <= 1'b1;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            idx         <= idx_d;
            in_init     <= in_init_d;
            dirty       <= dirty_d;
            o_wb_cyc    <= cyc_d;
            o_wb_stb    <= stb_d;
            o_wb_we     <= we_d;
            o_wb_sel    <= sel_d;
            o_wb_addr   <= addr_d;
            o_wb_data   <= data_d;
            o_init_done <= init_done_d;
            o_busy      <= busy_d;
        end
    end

`ifdef WB_LCD_SEQUENCER_TIMEOUT_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            to_cnt <= '0;
            o_err  <= 1'b0;
        end else begin
            to_cnt <= to_cnt_d;
            o_err  <= err_d;
        end
    end
`endif
endmodule

// File: tb/tb_wb_lcd_sequencer.sv
// Self-checking bench for wb_lcd_sequencer: responsive Wishbone slave plus a transaction-level model of the LCD stream.
module tb_wb_lcd_sequencer;
    localparam logic [29:0] BASE = 30'h0000_1230;
    localparam int unsigned PWR = 10, CMD_GAP = 4, CLR_GAP = 12, TMO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_reset, i_wb_ack, i_wb_stall, i_char_we, i_refresh;
    logic [4:0]  i_char_addr;
    logic [7:0]  i_char_data;
    logic        o_wb_cyc, o_wb_stb, o_wb_we, o_init_done, o_busy, o_err;
    logic [29:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic [3:0]  o_wb_sel;

    wb_lcd_sequencer #(
        .LCD_BASE_ADDR(BASE), .POWERUP_CYCLES(PWR), .CMD_GAP_CYCLES(CMD_GAP),
        .CLEAR_GAP_CYCLES(CLR_GAP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk(clk), .i_reset(i_reset),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_data(32'hDEAD_BEEF),
        .i_char_we(i_char_we), .i_char_addr(i_char_addr), .i_char_data(i_char_data),
        .i_refresh(i_refresh), .o_init_done(o_init_done), .o_busy(o_busy), .o_err(o_err)
    );

    typedef struct {
        logic [29:0] addr;
        logic [31:0] data;
        logic        we;
        logic [3:0]  sel;
    } txn_t;

    int   checks = 0, errors = 0, cycle = 0;
    txn_t obs[$];
    int   rise_q[$], fall_q[$];
    int   done_cycle = -1, rst_cycle = 0;
    int   stall_budget = 0, stall_seen = 0, ack_count = 0, pend = 0;
    bit   ack_rand = 0, no_ack_all = 0, no_ack_en = 0;
    logic [7:0]  no_ack_byte = 8'h00;
    logic        prev_stb = 1'b0, prev_cyc = 1'b0, prev_done = 1'b0;
    bit          hold_v = 0;
    logic [61:0] hold = '0;
    logic [7:0]  shadow_m [32];
    logic [7:0]  snap [32];

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Slave: optional stall, ack latency 0..2 after accept (or never), and event logging
    initial begin
        i_wb_ack = 1'b0;
        i_wb_stall = 1'b0;
        forever begin
            @(negedge clk);
            i_wb_ack = 1'b0;
            i_wb_stall = 1'b0;
            if (i_reset) begin
                pend = 0;
                hold_v = 0;
            end else begin
                if (o_wb_stb && !prev_stb) rise_q.push_back(cycle);
                if (!o_wb_cyc && prev_cyc) fall_q.push_back(cycle);
                if (o_init_done && !prev_done) done_cycle = cycle;
                if (o_wb_cyc && o_wb_stb) begin
                    if (hold_v) chk("stall_hold", 64'({o_wb_addr, o_wb_data}), 64'(hold));
                    if (stall_budget > 0) begin
                        i_wb_stall = 1'b1;
                        stall_budget--;
                        stall_seen++;
                        hold = {o_wb_addr, o_wb_data};
                        hold_v = 1;
                    end else begin
                        hold_v = 0;
                        obs.push_back('{o_wb_addr, o_wb_data, o_wb_we, o_wb_sel});
                        pend = ack_rand ? int'($urandom_range(0, 2)) : 1;
                        if (no_ack_all || (no_ack_en && o_wb_data[7:0] == no_ack_byte)) pend = -1;
                        if (pend == 0) begin
                            i_wb_ack = 1'b1;
                            ack_count++;
                        end
                    end
                end else if (o_wb_cyc && pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        i_wb_ack = 1'b1;
                        ack_count++;
                    end
                end
            end
            prev_stb = o_wb_stb;
            prev_cyc = o_wb_cyc;
            prev_done = o_init_done;
        end
    end

    task automatic release_reset();
        @(negedge clk);
        i_reset = 1'b0;
        rst_cycle = cycle;
        obs.delete();
        rise_q.delete();
        fall_q.delete();
        done_cycle = -1;
        for (int i = 0; i < 32; i++) shadow_m[i] = 8'h20;
    endtask

    task automatic wait_txns(input int n, input int budget);
        for (int c = 0; c < budget && obs.size() < n; c++) @(negedge clk);
        chk("wait_txns", 64'(obs.size() >= n), 64'(1));
    endtask

    task automatic wait_quiet(input int budget);
        int q = 0;
        for (int c = 0; c < budget && q < 8; c++) begin
            @(negedge clk);
            q = (!o_busy && !o_wb_cyc) ? q + 1 : 0;
        end
        chk("quiet", 64'(q >= 8), 64'(1));
    endtask

    task automatic check_txn(input string tag, input logic rs, input logic [7:0] b);
        txn_t t;
        chk({tag, "_avail"}, 64'(obs.size() > 0), 64'(1));
        if (obs.size() > 0) begin
            t = obs.pop_front();
            chk({tag, "_addr"}, 64'(t.addr), 64'(BASE | 30'(rs)));
            chk({tag, "_data"}, 64'(t.data), 64'({24'h0, b}));
            chk({tag, "_we_sel"}, 64'({t.we, t.sel}), 64'(5'b1_0001));
        end
    endtask

    // Expected refresh frame: set DDRAM line 1, 16 chars, set line 2, 16 chars
    task automatic check_refresh(input string tag, input logic [7:0] s [32]);
        check_txn({tag, "_cmd80"}, 1'b0, 8'h80);
        for (int i = 0; i < 16; i++) check_txn($sformatf("%s_b%0d", tag, i), 1'b1, s[i]);
        check_txn({tag, "_cmdC0"}, 1'b0, 8'hC0);
        for (int i = 16; i < 32; i++) check_txn($sformatf("%s_b%0d", tag, i), 1'b1, s[i]);
    endtask

    task automatic write_char(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        i_char_we = 1'b1;
        i_char_addr = a;
        i_char_data = d;
        shadow_m[a] = d;
        @(negedge clk);
        i_char_we = 1'b0;
    endtask

    task automatic pulse_refresh();
        @(negedge clk);
        i_refresh = 1'b1;
        @(negedge clk);
        i_refresh = 1'b0;
    endtask

    initial begin
        int k, nref;
        i_reset = 1'b1;
        i_char_we = 1'b0;
        i_char_addr = '0;
        i_char_data = '0;
        i_refresh = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cyc", 64'(o_wb_cyc), 64'(0));
        chk("rst_stb", 64'(o_wb_stb), 64'(0));
        chk("rst_we", 64'(o_wb_we), 64'(0));
        chk("rst_sel", 64'(o_wb_sel), 64'(0));
        chk("rst_addr", 64'(o_wb_addr), 64'(0));
        chk("rst_data", 64'(o_wb_data), 64'(0));
        chk("rst_init_done", 64'(o_init_done), 64'(0));
        chk("rst_busy", 64'(o_busy), 64'(1));
        chk("rst_err", 64'(o_err), 64'(0));

        // Power-up and init sequence with 1-cycle ack latency
        release_reset();
        wait_txns(4, 300);
        check_txn("init0", 1'b0, 8'h38);
        check_txn("init1", 1'b0, 8'h0C);
        check_txn("init2", 1'b0, 8'h01);
        check_txn("init3", 1'b0, 8'h06);
        chk("first_stb_cycle", 64'(rise_q[0] - rst_cycle), 64'(PWR));
        chk("gap_after_38", 64'(rise_q[1] - fall_q[0]), 64'(CMD_GAP));
        chk("gap_after_0C", 64'(rise_q[2] - fall_q[1]), 64'(CMD_GAP));
        chk("gap_after_01", 64'(rise_q[3] - fall_q[2]), 64'(CLR_GAP));
        for (int c = 0; c < 100 && !o_init_done; c++) @(negedge clk);
        chk("init_done", 64'(o_init_done), 64'(1));
        chk("init_done_time", 64'(done_cycle - fall_q[3]), 64'(CMD_GAP));

        // Boot refresh of all spaces, then stays idle
        wait_quiet(1500);
        check_refresh("boot", shadow_m);
        chk("boot_single", 64'(obs.size()), 64'(0));
        chk("idle_busy", 64'(o_busy), 64'(0));

        // 'A' at line 2 column 1
        write_char(5'd17, 8'h41);
        wait_quiet(1500);
        chk("a17_count", 64'(obs.size()), 64'(34));
        check_refresh("a17", shadow_m);

        // Random bursts of back-to-back writes with random ack latency
        ack_rand = 1;
        for (int r = 0; r < 4; r++) begin
            k = int'($urandom_range(1, 6));
            @(negedge clk);
            for (int w = 0; w < k; w++) begin
                i_char_we = 1'b1;
                i_char_addr = 5'($urandom);
                i_char_data = 8'($urandom_range(33, 126));
                shadow_m[i_char_addr] = i_char_data;
                @(negedge clk);
            end
            i_char_we = 1'b0;
            wait_quiet(3000);
            nref = (k >= 2) ? 2 : 1;
            chk($sformatf("rnd%0d_count", r), 64'(obs.size()), 64'(34 * nref));
            for (int f = 0; f < nref; f++) check_refresh($sformatf("rnd%0d_f%0d", r, f), shadow_m);
        end
        ack_rand = 0;

        // Forced refresh with the first request stalled for 5 cycles
        stall_seen = 0;
        ack_count = 0;
        stall_budget = 5;
        pulse_refresh();
        wait_quiet(1500);
        chk("stall_cycles", 64'(stall_seen), 64'(5));
        chk("stall_count", 64'(obs.size()), 64'(34));
        chk("stall_acks", 64'(ack_count), 64'(34));
        check_refresh("stall", shadow_m);

        // Write to an already-sent byte while byte 10 is pending
        snap = shadow_m;
        pulse_refresh();
        wait_txns(11, 500);
        write_char(5'd3, 8'h5A);
        wait_quiet(3000);
        chk("mid_count", 64'(obs.size()), 64'(68));
        check_refresh("mid_first", snap);
        check_refresh("mid_second", shadow_m);

        // Reset while waiting for an ack that never comes
        no_ack_all = 1;
        pulse_refresh();
        for (int c = 0; c < 50 && !(o_wb_cyc && !o_wb_stb); c++) @(negedge clk);
        chk("in_wait_ack", 64'({o_wb_cyc, o_wb_stb}), 64'(2'b10));
        i_reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_cyc", 64'({o_wb_cyc, o_wb_stb}), 64'(0));
        chk("rst_mid_busy", 64'(o_busy), 64'(1));
        chk("rst_mid_done", 64'(o_init_done), 64'(0));
        chk("rst_mid_err", 64'(o_err), 64'(0));
        no_ack_all = 0;
        release_reset();
        wait_txns(38, 1500);
        check_txn("reinit0", 1'b0, 8'h38);
        check_txn("reinit1", 1'b0, 8'h0C);
        check_txn("reinit2", 1'b0, 8'h01);
        check_txn("reinit3", 1'b0, 8'h06);
        check_refresh("spaces", shadow_m);

`ifdef WB_LCD_SEQUENCER_TIMEOUT_EN
        // Slave ignores 0x0C: timeout, sticky error, sequence continues with 0x01
        @(negedge clk);
        i_reset = 1'b1;
        no_ack_en = 1;
        no_ack_byte = 8'h0C;
        release_reset();
        wait_txns(3, 300);
        check_txn("to0", 1'b0, 8'h38);
        check_txn("to1", 1'b0, 8'h0C);
        check_txn("to2", 1'b0, 8'h01);
        chk("to_cyc_len", 64'(fall_q[1] - rise_q[1]), 64'(TMO));
        chk("to_err", 64'(o_err), 64'(1));
        no_ack_en = 0;
        no_ack_all = 1;
        for (int c = 0; c < 100 && !(o_wb_cyc && !o_wb_stb); c++) @(negedge clk);
        chk("to_in_wait", 64'({o_wb_cyc, o_wb_stb}), 64'(2'b10));
        i_reset = 1'b1;
        @(negedge clk);
        chk("to_rst_cyc", 64'(o_wb_cyc), 64'(0));
        chk("to_rst_err", 64'(o_err), 64'(0));
        no_ack_all = 0;
        release_reset();
`else
        chk("err_tied", 64'(o_err), 64'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
